// File: rtl/bus_master_arb.sv
// Round-robin bus master: grants one of NREQ requesters, drives dValid/data
// for MIN_CYC..MAX_CYC cycles and reports completion, timeout and early dAck.
module bus_master_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned MIN_CYC = 2,
  parameter int unsigned MAX_CYC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               dAck,
  output logic               dValid,
  output logic [DW-1:0]      data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               xfer_err,
  output logic               early_ack_err,
  output logic               busy
);

  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MIN_V = CW'(MIN_CYC);
  localparam logic [CW-1:0] MAX_V = CW'(MAX_CYC);

  typedef enum logic {
    IDLE,
    XFER
  } state_e;

  state_e            state_q, state_d;
  logic              dvalid_q, dvalid_d;
  logic [DW-1:0]     data_q, data_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              xfer_err_q, xfer_err_d;
  logic              early_q, early_d;
  logic              busy_q, busy_d;
  logic [CW-1:0]     vcnt_q, vcnt_d;
  logic [LW-1:0]     last_q, last_d;

  logic [NREQ-1:0]   elig;
  logic              found;
  logic [LW-1:0]     win;

  // Masking with done_q keeps the requester that just finished from winning
  // on the same edge its done pulse is visible.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    elig  = req & ~done_q;
    found = 1'b0;
    win   = last_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = k + 32'(last_q);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx[LW-1:0]]) begin
        found = 1'b1;
        win   = idx[LW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dvalid_d   = dvalid_q;
    data_d     = data_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    xfer_err_d = 1'b0;
    early_d    = 1'b0;
    vcnt_d     = vcnt_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = XFER;
          dvalid_d   = 1'b1;
          data_d     = req_data[32'(win)*DW +: DW];
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          vcnt_d     = CW'(1);
          last_d     = win;
        end
      end
      XFER: begin
        if (dAck && (vcnt_q >= MIN_V)) begin
          state_d  = IDLE;
          dvalid_d = 1'b0;
          gnt_d    = '0;
          done_d   = gnt_q;
        end else if (!dAck && (vcnt_q == MAX_V)) begin
          state_d    = IDLE;
          dvalid_d   = 1'b0;
          gnt_d      = '0;
          done_d     = gnt_q;
          xfer_err_d = 1'b1;
        end else begin
          vcnt_d = vcnt_q + CW'(1);
        end
        if (dAck && (vcnt_q < MIN_V)) early_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == XFER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dvalid_q   <= 1'b0;
      data_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      xfer_err_q <= 1'b0;
      early_q    <= 1'b0;
      busy_q     <= 1'b0;
      vcnt_q     <= '0;
      last_q     <= LW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      dvalid_q   <= dvalid_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      xfer_err_q <= xfer_err_d;
      early_q    <= early_d;
      busy_q     <= busy_d;
      vcnt_q     <= vcnt_d;
      last_q     <= last_d;
    end
  end

  assign dValid        = dvalid_q;
  assign data          = data_q;
  assign gnt           = gnt_q;
  assign done          = done_q;
  assign xfer_err      = xfer_err_q;
  assign early_ack_err = early_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_bus_master_arb.sv
// Scoreboard bench for bus_master_arb: transaction-level expectations are
// queued at request time and checked by an independent bus monitor.
module tb_bus_master_arb;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned MIN_CYC = 2;
  localparam int unsigned MAX_CYC = 4;
  localparam int unsigned NTX     = 40;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic               dAck;
  logic               dValid;
  logic [DW-1:0]      data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               xfer_err;
  logic               early_ack_err;
  logic               busy;

  bus_master_arb #(
    .NREQ(NREQ), .DW(DW), .MIN_CYC(MIN_CYC), .MAX_CYC(MAX_CYC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .dAck(dAck),
    .dValid(dValid), .data(data), .gnt(gnt), .done(done),
    .xfer_err(xfer_err), .early_ack_err(early_ack_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   w;
    logic [DW-1:0] d;
    int unsigned   len;
    bit            to;
    int unsigned   early;
    int            gap;
  } exp_t;

  exp_t             exp_q[$];
  logic [MAX_CYC:0] plan_q[$];
  int unsigned      own_q[$];

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Next owner: first requester after the previous winner, wrapping around.
  function automatic int unsigned rr_pick(input logic [NREQ-1:0] m, input int unsigned last);
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [MAX_CYC:0] rand_plan();
    logic [MAX_CYC:0] p;
    p = '0;
    for (int unsigned v = 1; v <= MAX_CYC; v++) p[v] = ($urandom % 3 == 0);
    return p;
  endfunction

  task automatic issue(input int unsigned w, input int gap, input logic [MAX_CYC:0] plan);
    exp_t e;
    e.w = w; e.d = req_data[w*DW +: DW]; e.len = MAX_CYC; e.to = 1'b1;
    e.early = 0; e.gap = gap;
    for (int unsigned v = MIN_CYC; v <= MAX_CYC; v++)
      if (e.to && plan[v]) begin e.len = v; e.to = 1'b0; end
    for (int unsigned v = 1; v < MIN_CYC; v++)
      if (plan[v]) e.early++;
    exp_q.push_back(e);
    plan_q.push_back(plan);
    own_q.push_back(w);
  endtask

  // Bus monitor: checks each transfer against the queued expectation.
  initial begin
    bit              prev, have;
    int unsigned     hi, early, lowc;
    exp_t            e;
    logic [NREQ-1:0] g0;
    logic [DW-1:0]   d0;
    prev = 0; have = 0; hi = 0; early = 0; lowc = 1000; g0 = '0; d0 = '0;
    e = '{default: 0};
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        prev = 0; lowc = 1000;
      end else begin
        if (dValid) begin
          if (!prev) begin
            have = (exp_q.size() > 0);
            checks++;
            if (!have) begin
              errors++;
              $display("FAIL start: got unexpected transfer gnt=%0h expected none", gnt);
            end else begin
              e = exp_q.pop_front();
              chk("gnt", 32'(gnt), 32'(1 << e.w));
              chk("data", 32'(data), 32'(e.d));
              if (e.gap > 0) chk("low_gap", lowc, e.gap);
            end
            g0 = gnt; d0 = data; hi = 1; early = 0;
          end else begin
            hi++;
            chk("gnt_stable", 32'(gnt), 32'(g0));
            chk("data_stable", 32'(data), 32'(d0));
          end
          if (early_ack_err) early++;
          chk("busy_hi", 32'(busy), 1);
          chk("done_in_xfer", 32'(done), 0);
        end else begin
          if (prev) begin
            if (early_ack_err) early++;
            if (have) begin
              chk("high_len", hi, e.len);
              chk("done", 32'(done), 32'(1 << e.w));
              chk("xfer_err", 32'(xfer_err), 32'(e.to));
              chk("early_cnt", early, e.early);
            end
            lowc = 1;
          end else begin
            chk("done_idle", 32'(done), 0);
            chk("xfer_err_idle", 32'(xfer_err), 0);
            chk("early_idle", 32'(early_ack_err), 0);
            lowc++;
          end
          chk("busy_lo", 32'(busy), 0);
        end
        prev = dValid;
      end
    end
  end

  // Stimulus: requesters, dAck driver and expectation generation.
  initial begin
    logic [NREQ-1:0]  pend, mask, others;
    logic [MAX_CYC:0] cur_plan;
    int unsigned      v, cur_own, last_m, n_issued, nb, idle_wait, idle_end;
    bit               cur_hold, dir, forced, ok, finished;
    reset = 1'b1; req = '0; req_data = '0; dAck = 1'b0;
    pend = '0; cur_plan = '0; v = 0; cur_own = 0; last_m = NREQ - 1;
    n_issued = 0; nb = 0; idle_wait = 0; idle_end = 0;
    cur_hold = 0; forced = 0; finished = 0; ok = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dValid", 32'(dValid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_xfer_err", 32'(xfer_err), 0);
    chk("rst_early", 32'(early_ack_err), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0; mon_en = 1'b1;

    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      @(posedge clk); #1;
      dir = (nb <= 5);
      if (dValid) begin
        v++;
        if (v == 1) begin
          if (plan_q.size() == 0) begin
            cur_plan = '0;
          end else begin
            cur_plan = plan_q.pop_front();
            cur_own  = own_q.pop_front();
          end
          last_m = cur_own;
          cur_hold = 0;
          if (dir && nb == 5 && !forced) begin
            cur_hold = 1; forced = 1;
          end else if (!dir && n_issued < NTX) begin
            cur_hold = ($urandom % 4 == 0);
          end
          if (cur_hold) req_data[cur_own*DW +: DW] = DW'($urandom);
          if (!dir && n_issued < NTX) begin
            for (int unsigned i = 0; i < NREQ; i++)
              if (!pend[i] && ($urandom % 3 == 0)) begin
                pend[i] = 1'b1; req[i] = 1'b1;
                req_data[i*DW +: DW] = DW'($urandom);
              end
          end
          others = pend;
          others[cur_own] = 1'b0;
          if (others != '0) begin
            issue(rr_pick(others, cur_own), 1, dir ? (MAX_CYC+1)'(1 << 3) : rand_plan());
            n_issued++;
          end else if (cur_hold) begin
            issue(cur_own, 2, dir ? (MAX_CYC+1)'(1 << 3) : rand_plan());
            n_issued++;
          end
        end
        dAck = (v <= MAX_CYC) ? cur_plan[v] : 1'b0;
      end else begin
        if (v > 0) begin
          if (!cur_hold) begin req[cur_own] = 1'b0; pend[cur_own] = 1'b0; end
          v = 0;
        end else if (plan_q.size() == 0 && n_issued < NTX) begin
          if (idle_wait > 0) begin
            idle_wait--;
          end else begin
            case (nb)
              0: mask = 4'b1111;
              1: mask = 4'b0001;
              2: mask = 4'b0100;
              3: mask = 4'b1000;
              4: mask = 4'b0010;
              default: mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            endcase
            for (int unsigned i = 0; i < NREQ; i++)
              if (mask[i]) req_data[i*DW +: DW] = DW'($urandom);
            if (nb == 1) req_data[0 +: DW] = 8'hA5;
            pend = mask; req = mask;
            case (nb)
              0: cur_plan = (MAX_CYC+1)'(1 << 3);
              1: cur_plan = (MAX_CYC+1)'(1 << 2);
              2: cur_plan = (MAX_CYC+1)'(3'b110);
              3: cur_plan = '0;
              4: cur_plan = (MAX_CYC+1)'(1 << 2);
              default: cur_plan = rand_plan();
            endcase
            issue(rr_pick(mask, last_m), -1, cur_plan);
            n_issued++; nb++;
            idle_wait = $urandom % 3;
          end
        end
        dAck = 1'($urandom % 2);
      end
      if (n_issued >= NTX && plan_q.size() == 0 && v == 0 && !dValid && pend == '0) begin
        idle_end++;
        if (idle_end >= 4) finished = 1;
      end else begin
        idle_end = 0;
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL timeout: got unfinished random phase expected completion");
    end
    chk("exp_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Asynchronous reset in the middle of a transfer from requester 2.
    dAck = 1'b0; req = 4'b0100; req_data[2*DW +: DW] = 8'h3C;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(posedge clk); #1; if (dValid) ok = 1; end
    chk("rst_mid_start", 32'(ok), 1);
    chk("rst_mid_gnt", 32'(gnt), 32'h4);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    chk("rst_mid_dValid", 32'(dValid), 0);
    chk("rst_mid_gnt0", 32'(gnt), 0);
    chk("rst_mid_data0", 32'(data), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    req = '0;
    repeat (2) begin @(negedge clk); chk("rst_mid_no_done", 32'(done), 0); end
    reset = 1'b0;
    req = 4'b0110; req_data[1*DW +: DW] = 8'h5A; req_data[2*DW +: DW] = 8'hC3;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(posedge clk); #1; if (dValid) ok = 1; end
    chk("post_rst_start", 32'(ok), 1);
    chk("post_rst_gnt", 32'(gnt), 32'h2);
    chk("post_rst_data", 32'(data), 32'h5A);

    // Second reset: the rotation pointer must return to its reset value.
    @(posedge clk); #2;
    reset = 1'b1; #1;
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1010; req_data[3*DW +: DW] = 8'h77;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin @(posedge clk); #1; if (dValid) ok = 1; end
    chk("rr_reset_start", 32'(ok), 1);
    chk("rr_reset_gnt", 32'(gnt), 32'h2);
    chk("rr_reset_data", 32'(data), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
